fpdiv_seq: RTL
==============

# fpdiv_seq

Control sequencer and operand/result buffer for the Goldschmidt floating-point divider datapath (`fpdiv`). The block accepts a divide request over a valid/ready handshake and latches the 27-bit operands. It then drives the datapath's mux selects and register enables through a fixed number of Goldschmidt iterations. Finally it captures the quotient significand and presents it over a second valid/ready handshake. It issues the control that the datapath only consumes.

## Interface
- `ITERS`, default 4: number of Goldschmidt iterations; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  sequencer can accept a request.
- `num_in`, `denom_in`  in  27 each  operand significands, Q3.23 (1.0 = 27'h80_0000).
- `num`, `denom`  out  27 each  latched operands, driven to the datapath.
- `sel_mux2`  out  1  datapath initial-guess/`regc` select; 0 = initial guess, 1 = `regc`.
- `sel_mux4`  out  2  datapath multiplicand select; 00 = `num`, 01 = `denom`, 10 = `rega`, 11 = `regb`.
- `en_a`, `en_b`, `en_c`  out  1 each  datapath register enables.
- `q_in`  in  27  datapath `rega` output (running quotient).
- `out`  out  24  captured quotient, equal to `q_in[23:0]` at capture.
- `out_valid`  out  1  `out` is valid.
- `out_ready`  in  1  consumer accepts `out`.

## Operation
- States: `IDLE`, `QSTEP`, `DSTEP`, `CAPT`, `HOLD`.
- `IDLE`:
  - `in_ready` = 1.
  - On `in_valid`, latch `num_in`/`denom_in` into `num`/`denom`.
  - Clear the iteration counter `it` and go to `QSTEP`.
- `QSTEP`:
  - `en_a` = 1.
  - `sel_mux2` = (`it` != 0).
  - `sel_mux4` = 00 when `it` == 0, otherwise 10.
  - Go to `DSTEP`.
- `DSTEP`:
  - `en_b` = `en_c` = 1.
  - `sel_mux2` = (`it` != 0).
  - `sel_mux4` = 01 when `it` == 0, otherwise 11.
  - Increment `it`.
  - If `it` == `ITERS`-1, go to `CAPT`; otherwise go to `QSTEP`.
- `CAPT`: register `q_in[23:0]` into `out`, set `out_valid`, go to `HOLD`.
- `HOLD`:
  - `out_valid` = 1 and `out` is held stable.
  - On `out_ready`, clear `out_valid` and go to `IDLE`.
- Enables are 0 in every state not listed above.
- Select outputs are 0 in `IDLE`, `CAPT` and `HOLD`.
- The final iteration's `DSTEP` executes even though its result is unused. This keeps every iteration identical.
- `in_valid` outside `IDLE` is ignored, and `in_ready` = 0 there.
- There is no bypass from `HOLD` to `QSTEP`. A new request is accepted only in `IDLE`, at the earliest the cycle after `out_ready`.
- Counter width is 4 bits and `it` never exceeds `ITERS`-1. An `ITERS` value outside 1..15 is a synthesis-time error.

## Timing
- Reset values:
  - State = `IDLE`, `in_ready` = 1.
  - `out_valid` = 0, `out` = 0, `num` = `denom` = 0.
  - All enables and selects = 0, `it` = 0.
- Reset mid-operation: next cycle is `IDLE`; enables drop immediately and any pending `out` is discarded.
- All outputs are registered except `in_ready`, which is decoded from state.
- Accept edge T: `QSTEP` of iteration 0 in cycle T+1; `DSTEP` in cycle T+2.
- Iteration i occupies cycles T+1+2i and T+2+2i.
- `CAPT` in cycle T+2·`ITERS`+1; `out_valid` rises at cycle T+2·`ITERS`+2.
- Latency for `ITERS`=4: 10 cycles from accept to `out_valid`.
- Minimum initiation interval: 2·`ITERS`+3 cycles when `out_ready` is tied high.
- `q_in` is sampled in `CAPT`. That is one cycle after the last `QSTEP` write, so `rega` has settled.

## Structure
- Shared package `fpdiv_pkg`:
  - State enum `fpdiv_state_t`.
  - Constants `MUX4_NUM`=2'b00, `MUX4_DEN`=2'b01, `MUX4_QA`=2'b10, `MUX4_QB`=2'b11.
  - `IA_SEL`=0, `RC_SEL`=1.
  - Significand width 27 and result width 24.
- One sub-module: `fpdiv_iter_cnt`, a loadable up-counter with a terminal-count flag (`it` == `ITERS`-1).
- Operand and result registers use the existing `flopenr`.

## Test plan
- Reset, then idle for 5 cycles: `in_ready`=1; `out_valid`, enables and selects all 0; `num`=`denom`=0.
- `ITERS`=4; accept num=27'h80_0000, denom=27'hC0_0000 at T:
  - Select/enable trace by cycle:
    - T+1: (0,00,a)
    - T+2: (0,01,bc)
    - T+3: (1,10,a)
    - T+4: (1,11,bc)
  - The pattern repeats to T+8. `CAPT` at T+9 and `out_valid`=1 at T+10.
  - `num`/`denom` stay constant for the whole operation.
- Drive `q_in`=27'h55_5555 during `CAPT` with `out_ready`=0 for 3 cycles:
  - `out`=24'h55_5555 held with `out_valid`=1.
  - Raise `out_ready`: `out_valid`=0 and `in_ready`=1 the next cycle.
- Hold `in_valid`=1 with new operands during `QSTEP`/`DSTEP`/`HOLD`: latched operands are unchanged and no second operation starts until `IDLE`.
- Assert `reset` at T+5 mid-iteration: next cycle shows `IDLE`, enables 0 and `out_valid` 0. The next request then produces the full 10-cycle sequence.
- `ITERS`=1 build: accept at T gives `QSTEP` at T+1, `DSTEP` at T+2, `CAPT` at T+3 and `out_valid` at T+4. Back-to-back requests with `out_ready`=1 start 5 cycles apart.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer.
package fpdiv_pkg;

  localparam int SIG_W = 27;  // operand significand width, Q3.23
  localparam int RES_W = 24;  // captured quotient width
  localparam int CNT_W = 4;   // iteration counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QSTEP = 3'd1,
    DSTEP = 3'd2,
    CAPT  = 3'd3,
    HOLD  = 3'd4
  } fpdiv_state_t;

  // Datapath multiplicand select codes
  localparam logic [1:0] MUX4_NUM = 2'b00;
  localparam logic [1:0] MUX4_DEN = 2'b01;
  localparam logic [1:0] MUX4_QA  = 2'b10;
  localparam logic [1:0] MUX4_QB  = 2'b11;

  // Datapath initial-guess / regc select codes
  localparam logic IA_SEL = 1'b0;
  localparam logic RC_SEL = 1'b1;

endpackage

// File: rtl/flopenr.sv
// Resettable register with load enable.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; synchronous clear on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fpdiv_iter_cnt.sv
// Goldschmidt iteration counter: clearable up-counter with a terminal-count
// flag at ITERS-1. The next-cycle value is exported so the sequencer can
// register its selects in step with the count.
module fpdiv_iter_cnt
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(ITERS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins; on terminal count wrap to 0 so the count
  // never exceeds ITERS-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;
  assign tc       = (cnt_q == TC_VAL);

endmodule

// File: rtl/fpdiv_seq.sv
// Control sequencer and operand/result buffer for the Goldschmidt divider.
// Outputs are decoded from the next state and registered so that each
// control value is visible in the cycle the state occupies.
module fpdiv_seq
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] num_in,
  input  logic [SIG_W-1:0] denom_in,
  output logic [SIG_W-1:0] num,
  output logic [SIG_W-1:0] denom,
  output logic             sel_mux2,
  output logic [1:0]       sel_mux4,
  output logic             en_a,
  output logic             en_b,
  output logic             en_c,
  input  logic [SIG_W-1:0] q_in,
  output logic [RES_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  if (ITERS < 1 || ITERS > 15) begin : g_bad_iters
    $error("fpdiv_seq: ITERS must be in 1..15");
  end

  fpdiv_state_t     state_q, state_d;
  logic             sel_mux2_q, sel_mux2_d;
  logic [1:0]       sel_mux4_q, sel_mux4_d;
  logic             en_a_q, en_a_d;
  logic             en_bc_q, en_bc_d;
  logic             out_valid_q, out_valid_d;

  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] it_cur, it_next;
  logic             opnd_en, res_en;

  // Only the low 24 bits of the running quotient form the result
  logic             unused_q_hi;
  assign unused_q_hi = ^q_in[SIG_W-1:RES_W];

  fpdiv_iter_cnt #(
    .ITERS (ITERS)
  ) u_iter_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (it_cur),
    .cnt_next (it_next),
    .tc       (cnt_tc)
  );

  // Next-state, counter control, and next-cycle control outputs
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    opnd_en     = 1'b0;
    res_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_en = 1'b1;
          cnt_clr = 1'b1;
          state_d = QSTEP;
        end
      end
      QSTEP: state_d = DSTEP;
      DSTEP: begin
        cnt_inc = 1'b1;
        state_d = cnt_tc ? CAPT : QSTEP;
      end
      CAPT: begin
        res_en  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    en_a_d      = (state_d == QSTEP);
    en_bc_d     = (state_d == DSTEP);
    out_valid_d = (state_d == HOLD);
    sel_mux2_d  = IA_SEL;
    sel_mux4_d  = MUX4_NUM;
    if (state_d == QSTEP) begin
      sel_mux2_d = (it_next != '0) ? RC_SEL : IA_SEL;
      sel_mux4_d = (it_next == '0) ? MUX4_NUM : MUX4_QA;
    end else if (state_d == DSTEP) begin
      sel_mux2_d = (it_next != '0) ? RC_SEL : IA_SEL;
      sel_mux4_d = (it_next == '0) ? MUX4_DEN : MUX4_QB;
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_mux2_q  <= IA_SEL;
      sel_mux4_q  <= MUX4_NUM;
      en_a_q      <= 1'b0;
      en_bc_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_mux2_q  <= sel_mux2_d;
      sel_mux4_q  <= sel_mux4_d;
      en_a_q      <= en_a_d;
      en_bc_q     <= en_bc_d;
      out_valid_q <= out_valid_d;
    end
  end

  flopenr #(.WIDTH(SIG_W)) u_num_reg (
    .clk(clk), .reset(reset), .en(opnd_en), .d(num_in), .q(num)
  );

  flopenr #(.WIDTH(SIG_W)) u_denom_reg (
    .clk(clk), .reset(reset), .en(opnd_en), .d(denom_in), .q(denom)
  );

  flopenr #(.WIDTH(RES_W)) u_out_reg (
    .clk(clk), .reset(reset), .en(res_en), .d(q_in[RES_W-1:0]), .q(out)
  );

  // The counter value itself is only needed one cycle ahead
  logic unused_it_cur;
  assign unused_it_cur = ^it_cur;

  assign in_ready  = (state_q == IDLE);
  assign sel_mux2  = sel_mux2_q;
  assign sel_mux4  = sel_mux4_q;
  assign en_a      = en_a_q;
  assign en_b      = en_bc_q;
  assign en_c      = en_bc_q;
  assign out_valid = out_valid_q;

endmodule
